// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and iteration count for muldiv_unit.
package muldiv_pkg;
    localparam int ITERS = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on {hi, lo} over a shared XLEN+1 bit adder.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = ITERS
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] m,
    output logic [XLEN-1:0] hi_n,
    output logic [XLEN-1:0] lo_n
);
    logic [XLEN:0]   x, y;
    logic [XLEN+1:0] s;

    // Divide subtracts via inverted operand plus carry-in; carry-out set means no restore.
    always_comb begin
        x    = is_div ? {hi, lo[XLEN-1]} : {1'b0, hi};
        y    = is_div ? ~{1'b0, m} : (lo[0] ? {1'b0, m} : '0);
        s    = {1'b0, x} + {1'b0, y} + {{(XLEN+1){1'b0}}, is_div};
        hi_n = is_div ? (s[XLEN+1] ? s[XLEN-1:0] : x[XLEN-1:0]) : s[XLEN:1];
        lo_n = is_div ? {lo[XLEN-2:0], s[XLEN+1]} : {s[0], lo[XLEN-1:1]};
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (IDLE/RUN/DONE), magnitude datapath with final sign fix.
// Define MULDIV_DIV_EN to include the divide/remainder datapath; without it ops 1xx complete at once with 0.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = ITERS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    localparam logic [5:0] LAST = 6'(XLEN);

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic            neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [XLEN-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic [XLEN-1:0] hi_n, lo_n, mul_res, div_res;
    logic [2*XLEN-1:0] prod;
    logic            a_sgn, b_sgn, is_div, skip;

    assign a_sgn   = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    assign b_sgn   = op[2] ? ~op[0] : ~op[1];
    assign prod    = (neg_a_q ^ neg_b_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
    assign is_div  = op_q[2];
    assign skip    = 1'b0;
    // A zero divisor leaves the all-ones quotient unsigned; the remainder always follows the dividend.
    assign div_res = op_q[1] ? (neg_a_q ? -hi_q : hi_q)
                             : (((neg_a_q ^ neg_b_q) && (m_q != '0)) ? -lo_q : lo_q);
`else
    assign is_div  = 1'b0;
    assign skip    = op[2];
    assign div_res = '0;
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div (is_div),
        .hi     (hi_q),
        .lo     (lo_q),
        .m      (m_q),
        .hi_n   (hi_n),
        .lo_n   (lo_n)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                op_d    = op;
                rd_d    = rd_in;
                neg_a_d = a_sgn & a[XLEN-1];
                neg_b_d = b_sgn & b[XLEN-1];
                hi_d    = '0;
                lo_d    = neg_a_d ? -a : a;
                m_d     = neg_b_d ? -b : b;
                cnt_d   = '0;
                state_d = skip ? S_DONE : S_RUN;
                res_d   = skip ? '0 : res_q;
                done_d  = skip;
                busy_d  = ~skip;
            end
            S_RUN: if (cnt_q == LAST) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                res_d   = op_q[2] ? div_res : mul_res;
            end else begin
                hi_d   = hi_n;
                lo_d   = lo_n;
                cnt_d  = cnt_q + 6'd1;
                busy_d = 1'b1;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q;
    assign rd_out = rd_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed scoreboard bench for muldiv_unit; divide cases follow MULDIV_DIV_EN.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Call with clk low; start is sampled on the next rising edge. spoil re-pulses start mid-run.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r, input logic [31:0] er, input int elat, input bit spoil);
        exp_t e;
        int   lat;
        sb.push_back('{res: er, rd: r, lat: elat});
        op = o; a = x; b = y; rd_in = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, {31'b0, busy}, {31'b0, elat != 0});
        lat = 0;
        while (!done && lat < 60) begin
            if (spoil && lat == 5) begin
                op = OP_MULHU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; rd_in = 5'd9; start = 1'b1;
            end else start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        e = sb.pop_front();
        chk({tag, "_lat"}, lat, e.lat);
        chk({tag, "_res"}, result, e.res);
        chk({tag, "_rd"}, {27'b0, rd_out}, {27'b0, e.rd});
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, {31'b0, done}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #3;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", {27'b0, rd_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("mul_7x6", OP_MUL, 32'd7, 32'd6, 5'd5, 32'd42, 33, 1'b0);
        do_op("mul_neg", OP_MUL, 32'hFFFF_FFFD, 32'd5, 5'd1, 32'hFFFF_FFF1, 33, 1'b0);
        do_op("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 33, 1'b0);
        do_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 33, 1'b0);
        do_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFF, 33, 1'b0);
`ifdef MULDIV_DIV_EN
        do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33, 1'b0);
        do_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 33, 1'b0);
        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd8, 32'd14, 33, 1'b0);
        do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd9, 32'd2, 33, 1'b0);
        do_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 33, 1'b0);
        do_op("remu_by0", OP_REMU, 32'd5, 32'd0, 5'd11, 32'd5, 33, 1'b0);
        do_op("div_m5_by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFF, 33, 1'b0);
        do_op("rem_m5_by0", OP_REM, 32'hFFFF_FFFB, 32'd0, 5'd13, 32'hFFFF_FFFB, 33, 1'b0);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 33, 1'b0);
        do_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 33, 1'b0);
`else
        do_op("div_off", OP_DIV, 32'd9, 32'd3, 5'd16, 32'd0, 0, 1'b0);
        do_op("mul_3x3", OP_MUL, 32'd3, 32'd3, 5'd17, 32'd9, 33, 1'b0);
`endif
        op = OP_MUL; a = 32'd11; b = 32'd13; rd_in = 5'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_rd", {27'b0, rd_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("post_rst", OP_MUL, 32'd4, 32'd5, 5'd21, 32'd20, 33, 1'b0);
        do_op("spoil", OP_MUL, 32'd7, 32'd6, 5'd5, 32'd42, 33, 1'b1);
        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port a  input  XLEN  rs1 operand, register-file read port 1 value.
REQ-007 SHALL have port b  input  XLEN  rs2 operand, register-file read port 2 value.
REQ-008 SHALL have port rd_in  input  5  destination register tag.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse, usable directly as register-file write enable.
REQ-011 SHALL have port result  output  XLEN  registered result; valid when done=1 and held until the next done.
REQ-012 SHALL have port rd_out  output  5  tag captured at start; feeds register-file rd.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1 at edge N, capture op, rd_in, |a|, |b| and the sign flags, then enter RUN.
REQ-015 SHALL run exactly XLEN iterations in RUN, one per cycle: shift-add multiply or restoring divide, with a 6-bit iteration counter.
REQ-016 SHALL, after the last iteration, apply sign correction, load result, enter DONE, and drive done=1 at the cycle starting at edge N+XLEN+1.
REQ-017 SHALL return from DONE to IDLE unconditionally after one cycle.
REQ-018 SHALL drive busy=1 in RUN and busy=0 in IDLE and DONE.
REQ-019 SHALL ignore start when the FSM is not in IDLE; captured operands SHALL NOT change.
REQ-020 SHALL return the low XLEN bits of the 2*XLEN product for MUL and the high XLEN bits for MULH, MULHSU and MULHU.
REQ-021 SHALL, for MULHSU, treat a as signed and b as unsigned.
REQ-022 SHALL truncate DIV and REM toward zero, with the remainder taking the dividend's sign.
REQ-023 SHALL, for divide by zero, return all ones as quotient and the dividend as remainder, with the normal latency.
REQ-024 SHALL, for signed overflow (0x80000000 / -1), return quotient 0x80000000 and remainder 0.
REQ-025 SHALL keep done=0 outside DONE; rd_out SHALL be stable from capture through DONE.

Reset
REQ-026 SHALL, while rst=1, immediately force state=IDLE, busy=0, done=0, result=0, rd_out=0 and counter=0, independent of clk.
REQ-027 SHALL abort any in-flight operation on reset mid-RUN: no done pulse, no write.
REQ-028 SHALL accept a start on the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL, with macro MULDIV_DIV_EN defined, implement all eight ops as above.
REQ-030 SHALL, with MULDIV_DIV_EN undefined, omit the divide datapath; ops 1xx SHALL go IDLE -> DONE in one cycle with result=0, and multiply behaviour SHALL be unchanged.

Structure
REQ-031 SHALL place the op encodings, the FSM state encoding and the ITERS=XLEN constant in shared package muldiv_pkg.
REQ-032 SHALL place the per-iteration 33-bit add/subtract-and-shift datapath in one sub-module, muldiv_step; all other logic stays in muldiv_unit.

Verification
REQ-033 SHALL cover: MUL a=7, b=6, rd_in=5 -> done exactly 33 cycles after the start edge, result=42, rd_out=5.
REQ-034 SHALL cover: MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
REQ-035 SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-036 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
REQ-037 SHALL cover: rst pulsed at RUN iteration 10 -> busy=0 immediately and no done; start re-pulsed at iteration 5 of a later op -> ignored, original result returned.
REQ-038 SHALL cover: build without MULDIV_DIV_EN, DIV 9/3 -> done one cycle after start, result=0; MUL 3*3 -> 9 after 33 cycles.
